// File: rtl/timer_host_master_if.sv
// timer_host_master_if: client command/status and Avalon-MM timer bus seen by the master
interface timer_host_master_if #(
  parameter int TICK_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_period;
  logic              cmd_continuous;
  logic              cmd_irq_en;
  logic              snap_valid;
  logic [31:0]       snap_value;
  logic              tick;
  logic [TICK_W-1:0] tick_count;
  logic [2:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [15:0]       avm_writedata;
  logic [15:0]       avm_readdata;
  logic              irq;
  modport master (
    input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en, avm_readdata, irq,
    output cmd_ready, snap_valid, snap_value, tick, tick_count,
           avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en, avm_readdata, irq,
    input  cmd_ready, snap_valid, snap_value, tick, tick_count,
           avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/timer_host_master.sv
// timer_host_master: turns start/stop/snapshot commands into interval-timer register sequences and services its irq
module timer_host_master #(
  parameter int TICK_W       = 32,
  parameter bit CLR_ON_START = 1'b1
) (
  input logic clk,
  input logic reset,
  timer_host_master_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP,
    SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE,
    IRQ_CLR, IRQ_WAIT
  } state_t;
  state_t            state_q, state_d;
  logic [31:0]       period_q, period_d;
  logic              cont_q, cont_d, ito_q, ito_d;
  logic [15:0]       snap_lo_q, snap_lo_d;
  logic [31:0]       snap_value_q, snap_value_d;
  logic              snap_valid_q, snap_valid_d;
  logic              tick_q, tick_d;
  logic [TICK_W-1:0] tick_count_q, tick_count_d;
  logic [2:0]        address_q, address_d;
  logic              chipselect_q, chipselect_d;
  logic              write_n_q, write_n_d;
  logic [15:0]       writedata_q, writedata_d;
  logic              accept;
  assign bus.cmd_ready      = (state_q == IDLE) && !bus.irq && !reset;
  assign accept             = bus.cmd_valid && bus.cmd_ready;
  assign bus.snap_valid     = snap_valid_q;
  assign bus.snap_value     = snap_value_q;
  assign bus.tick           = tick_q;
  assign bus.tick_count     = tick_count_q;
  assign bus.avm_address    = address_q;
  assign bus.avm_chipselect = chipselect_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_writedata  = writedata_q;
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    cont_d       = cont_q;
    ito_d        = ito_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    case (state_q)
      IDLE: begin
        if (bus.irq) state_d = IRQ_CLR;
        else if (accept) begin
          case (bus.cmd_op)
            2'd0: begin
              state_d  = WR_PL;
              period_d = bus.cmd_period;
              cont_d   = bus.cmd_continuous;
              ito_d    = bus.cmd_irq_en;
              if (CLR_ON_START) tick_count_d = '0;
            end
            2'd1:    state_d = WR_STOP;
            2'd2:    state_d = SNAP_WR;
            default: state_d = IDLE;
          endcase
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTL;
      WR_CTL:  state_d = IDLE;
      WR_STOP: state_d = IDLE;
      SNAP_WR: state_d = SNAP_RL;
      SNAP_RL: state_d = SNAP_RH;
      // readdata lags the address by one cycle, so each half is captured one state later
      SNAP_RH: begin
        snap_lo_d = bus.avm_readdata;
        state_d   = SNAP_DONE;
      end
      SNAP_DONE: begin
        snap_value_d = {bus.avm_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = IDLE;
      end
      IRQ_CLR: begin
        tick_d       = 1'b1;
        tick_count_d = tick_count_q + 1'b1;
        state_d      = IRQ_WAIT;
      end
      IRQ_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // bus outputs are registered from the next state so each state owns exactly one bus cycle
    chipselect_d = !(state_d inside {IDLE, IRQ_WAIT});
    write_n_d    = state_d inside {IDLE, IRQ_WAIT, SNAP_RL, SNAP_RH, SNAP_DONE};
    address_d    = 3'd0;
    writedata_d  = 16'h0000;
    case (state_d)
      WR_PL: begin
        address_d   = 3'd2;
        writedata_d = period_d[15:0];
      end
      WR_PH: begin
        address_d   = 3'd3;
        writedata_d = period_d[31:16];
      end
      WR_CTL: begin
        address_d   = 3'd1;
        writedata_d = {12'h000, 2'b01, cont_d, ito_d};
      end
      WR_STOP: begin
        address_d   = 3'd1;
        writedata_d = {12'h000, 2'b10, cont_d, ito_d};
      end
      SNAP_WR, SNAP_RL:   address_d = 3'd4;
      SNAP_RH, SNAP_DONE: address_d = 3'd5;
      default:            address_d = 3'd0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      ito_q        <= 1'b0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      address_q    <= '0;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      writedata_q  <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      ito_q        <= ito_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      address_q    <= address_d;
      chipselect_q <= chipselect_d;
      write_n_q    <= write_n_d;
      writedata_q  <= writedata_d;
    end
  end
endmodule

// File: tb/tb_timer_host_master.sv
// tb_timer_host_master: randomized commands and irqs against a queue-based reference of expected bus writes, snapshots and ticks
module tb_timer_host_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  timer_host_master_if #(.TICK_W(4)) bif();
  timer_host_master #(.TICK_W(4), .CLR_ON_START(1'b1)) dut (.clk(clk), .reset(reset), .bus(bif.master));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] wq[$];
  logic [31:0] sq[$];
  logic [3:0]  tq[$];
  int   mcount = 0;
  logic mc = 1'b0, mi = 1'b0;
  logic [15:0] snap_l = 16'h0, snap_h = 16'h0;
  logic [15:0] r4 = 16'h0, r5 = 16'h0;
  // timer slave: a4 write captures the counter snapshot, reads return one cycle after the address
  always @(posedge clk) begin
    if (bif.avm_chipselect && !bif.avm_write_n && bif.avm_address == 3'd4) begin
      r4 <= snap_l;
      r5 <= snap_h;
    end
    if (bif.avm_chipselect && bif.avm_write_n)
      bif.avm_readdata <= (bif.avm_address == 3'd4) ? r4 : (bif.avm_address == 3'd5) ? r5 : 16'h0;
  end
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.avm_chipselect && !bif.avm_write_n) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL write_extra: got a=%0d d=%h expected no write at %0t", bif.avm_address, bif.avm_writedata, $time);
        end else chk("bus_write", {bif.avm_address, bif.avm_writedata}, wq.pop_front());
      end
      if (bif.snap_valid) begin
        if (sq.size() == 0) chk("snap_extra", 1, 0);
        else chk("snap_value", bif.snap_value, sq.pop_front());
      end
      if (bif.tick) begin
        if (tq.size() == 0) chk("tick_extra", 1, 0);
        else chk("tick_count_at_tick", bif.tick_count, tq.pop_front());
      end
    end
  end
  task automatic push_irq();
    wq.push_back({3'd0, 16'h0000});
    mcount = (mcount + 1) % 16;
    tq.push_back(4'(mcount));
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic c, input logic i, input bit with_irq);
    int w;
    int lat;
    int exp_lat;
    bit ok = 1'b0;
    @(posedge clk); #1;
    bif.cmd_op = op;
    bif.cmd_period = per;
    bif.cmd_continuous = c;
    bif.cmd_irq_en = i;
    bif.cmd_valid = 1'b1;
    if (with_irq) begin
      bif.irq = 1'b1;
      push_irq();
    end
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (with_irq && w == 0) chk("irq_priority_ready", bif.cmd_ready, 0);
      if (bif.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (with_irq && w == 1) bif.irq = 1'b0;
    end
    if (!ok) begin
      chk("accept_timeout", 1, 0);
      bif.cmd_valid = 1'b0;
      bif.irq = 1'b0;
      return;
    end
    if (with_irq) chk("accept_after_irq_wait", w, 3);
    case (op)
      2'd0: begin
        wq.push_back({3'd2, per[15:0]});
        wq.push_back({3'd3, per[31:16]});
        wq.push_back({3'd1, 12'h000, 2'b01, c, i});
        mc = c;
        mi = i;
        mcount = 0;
        exp_lat = 4;
      end
      2'd1: begin
        wq.push_back({3'd1, 12'h000, 2'b10, mc, mi});
        exp_lat = 2;
      end
      2'd2: begin
        wq.push_back({3'd4, 16'h0000});
        sq.push_back({snap_h, snap_l});
        exp_lat = 5;
      end
      default: exp_lat = 1;
    endcase
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    for (lat = 1; lat < 20; lat++) begin
      @(negedge clk);
      if (op == 2'd2) chk("snap_valid_timing", bif.snap_valid, lat == 5);
      if (bif.cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("ready_latency", lat, exp_lat);
    chk("tick_count_model", bif.tick_count, mcount);
  endtask
  task automatic irq_pulse(input int len);
    @(posedge clk); #1;
    bif.irq = 1'b1;
    push_irq();
    repeat (len) begin @(posedge clk); #1; end
    bif.irq = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_cmd_ready"}, bif.cmd_ready, 0);
    chk({nm, "_cs"}, bif.avm_chipselect, 0);
    chk({nm, "_write_n"}, bif.avm_write_n, 1);
    chk({nm, "_addr"}, bif.avm_address, 0);
    chk({nm, "_wdata"}, bif.avm_writedata, 0);
    chk({nm, "_snap_valid"}, bif.snap_valid, 0);
    chk({nm, "_snap_value"}, bif.snap_value, 0);
    chk({nm, "_tick"}, bif.tick, 0);
    chk({nm, "_tick_count"}, bif.tick_count, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_op = 2'd0;
    bif.cmd_period = 32'h0;
    bif.cmd_continuous = 1'b0;
    bif.cmd_irq_en = 1'b0;
    bif.irq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;
    issue(2'd0, 32'h000F423F, 1'b1, 1'b1, 1'b0);
    issue(2'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    snap_l = 16'h1234;
    snap_h = 16'h0056;
    issue(2'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("snap_directed", bif.snap_value, 32'h00561234);
    irq_pulse(3);
    chk("tick_after_irq", bif.tick_count, 1);
    issue(2'd0, 32'h0001_0002, 1'b0, 1'b1, 1'b1);
    repeat (16) irq_pulse(1);
    chk("tick_wrap", bif.tick_count, 0);
    for (int k = 0; k < 50; k++) begin
      int r = int'($urandom_range(0, 4));
      snap_l = 16'($urandom);
      snap_h = 16'($urandom);
      if (r == 4) irq_pulse(int'($urandom_range(1, 3)));
      else issue(2'(r), $urandom, 1'($urandom), 1'($urandom), (r == 0) && ($urandom_range(0, 3) == 0));
    end
    @(posedge clk); #1;
    bif.cmd_op = 2'd0;
    bif.cmd_period = 32'hABCD_1357;
    bif.cmd_continuous = 1'b1;
    bif.cmd_irq_en = 1'b0;
    bif.cmd_valid = 1'b1;
    @(negedge clk);
    chk("rst_seq_ready", bif.cmd_ready, 1);
    wq.push_back({3'd2, 16'h1357});
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    wq.delete();
    mcount = 0;
    mc = 1'b0;
    mi = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    issue(2'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    chk("writes_left", wq.size(), 0);
    chk("snaps_left", sq.size(), 0);
    chk("ticks_left", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
